// File: rtl/ilm_pkg.sv
// ilm_pkg: shared constants and helpers for the Improved Logarithmic Multiplier.
//   IN_W     operand width (two's complement)
//   OUT_W    product width (two's complement)
//   MAG_W    signed width of the shift/add intermediate
//   K_W      width of a rounded exponent K (0..IN_W)
//   Q_W      signed width of a rounding remainder q = m - 2^K
//   PROD_MAX / PROD_MIN  saturation limits of the product output
package ilm_pkg;

  localparam int IN_W  = 9;
  localparam int OUT_W = 2 * IN_W - 1;
  localparam int MAG_W = 2 * IN_W + 1;
  localparam int K_W   = $clog2(IN_W + 1);
  localparam int Q_W   = IN_W + 1;

  localparam logic signed [OUT_W-1:0] PROD_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] PROD_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // Magnitude of a two's complement operand as an unsigned IN_W-bit value.
  // The most negative input maps onto 2^(IN_W-1), which still fits unsigned.
  function automatic logic [IN_W-1:0] abs_mag(input logic [IN_W-1:0] v);
    abs_mag = v[IN_W-1] ? (~v + IN_W'(1)) : v;
  endfunction

endpackage

// File: rtl/ilm_round_pow2.sv
// ilm_round_pow2: rounds an unsigned magnitude to its nearest power of two.
//   mag_i   unsigned operand magnitude
//   k_o     exponent K of the chosen power of two
//   q_o     signed remainder mag_i - 2^K (negative when rounded up)
//   zero_o  magnitude is zero (k_o/q_o are then meaningless)
module ilm_round_pow2
  import ilm_pkg::*;
(
  input  logic [IN_W-1:0]       mag_i,
  output logic [K_W-1:0]        k_o,
  output logic signed [Q_W-1:0] q_o,
  output logic                  zero_o
);

  logic [K_W-1:0] lead;
  logic [IN_W:0]  mag_up;
  logic           round_up;
  logic [Q_W-1:0] p2;

  // Leading-one detector: the highest set bit wins.
  always_comb begin
    lead = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (mag_i[i]) lead = K_W'(i);
    end
  end

  // Bit i of mag_up is mag_i[i-1], so indexing with the leading-one position
  // reads the bit just below it, and reads the padded 0 when lead is 0.
  assign mag_up   = {mag_i, 1'b0};
  assign round_up = mag_up[lead];

  assign k_o    = lead + K_W'(round_up);
  assign p2     = Q_W'(1) << k_o;
  assign q_o    = $signed({1'b0, mag_i}) - $signed(p2);
  assign zero_o = ~|mag_i;

endmodule

// File: rtl/ilm_mult.sv
// ilm_mult: signed approximate multiplier (Improved Logarithmic Multiplier).
// Each operand magnitude is rounded to its nearest power of two and the
// product is formed as 2^(Ka+Kb) + qa*2^Kb + qb*2^Ka, then signed and
// saturated. One registered output stage, one cycle latency.
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands valid this cycle
//   in1, in2   signed operands
//   out_valid  product/carry valid (in_valid delayed one cycle)
//   product    signed approximate product (holds when no new operands)
//   carry      product was saturated
module ilm_mult
  import ilm_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in1,
  input  logic signed [IN_W-1:0]  in2,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] product,
  output logic                    carry
);

  localparam logic signed [MAG_W-1:0] LIM_HI = {{(MAG_W-OUT_W){1'b0}}, PROD_MAX};
  localparam logic signed [MAG_W-1:0] LIM_LO = {{(MAG_W-OUT_W){1'b1}}, PROD_MIN};

  logic                    sign_res;
  logic [IN_W-1:0]         mag_a, mag_b;
  logic [K_W-1:0]          k_a, k_b;
  logic signed [Q_W-1:0]   q_a, q_b;
  logic                    zero_a, zero_b;

  logic [K_W:0]            k_sum;
  logic signed [MAG_W-1:0] pow_term, q_a_ext, q_b_ext, mag_m, res_m;

  logic signed [OUT_W-1:0] product_d, product_q;
  logic                    carry_d, carry_q;
  logic                    out_valid_q;

  assign sign_res = in1[IN_W-1] ^ in2[IN_W-1];
  assign mag_a    = abs_mag(in1);
  assign mag_b    = abs_mag(in2);

  ilm_round_pow2 u_round_a (
    .mag_i  (mag_a),
    .k_o    (k_a),
    .q_o    (q_a),
    .zero_o (zero_a)
  );

  ilm_round_pow2 u_round_b (
    .mag_i  (mag_b),
    .k_o    (k_b),
    .q_o    (q_b),
    .zero_o (zero_b)
  );

  // Shift/add core. Each cross term is below 2^(Ka+Kb-1) in magnitude, so
  // MAG_W signed bits cover the sum and its negation without wrap.
  assign k_sum    = {1'b0, k_a} + {1'b0, k_b};
  assign pow_term = MAG_W'(1) << k_sum;
  assign q_a_ext  = {{(MAG_W-Q_W){q_a[Q_W-1]}}, q_a};
  assign q_b_ext  = {{(MAG_W-Q_W){q_b[Q_W-1]}}, q_b};
  assign mag_m    = pow_term + (q_a_ext <<< k_b) + (q_b_ext <<< k_a);
  assign res_m    = sign_res ? -mag_m : mag_m;

  always_comb begin
    product_d = res_m[OUT_W-1:0];
    carry_d   = 1'b0;
    if (zero_a || zero_b) begin
      product_d = '0;
    end else if (res_m > LIM_HI) begin
      product_d = PROD_MAX;
      carry_d   = 1'b1;
    end else if (res_m < LIM_LO) begin
      product_d = PROD_MIN;
      carry_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      product_q   <= '0;
      carry_q     <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        product_q <= product_d;
        carry_q   <= carry_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_ilm_mult.sv
// Scoreboard bench for ilm_mult: the stimulus process pushes hand-computed
// expected results; a monitor pops and compares whenever out_valid is high,
// and checks hold/reset behaviour on the other cycles.
module tb_ilm_mult;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic signed [8:0] in1, in2;
  logic              out_valid;
  logic signed [16:0] product;
  logic              carry;

  ilm_mult dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .product   (product),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int p;
    int c;
  } vec_t;

  typedef struct {
    int a;
    int b;
    int p;
    int c;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[16];

  int n_tests = 0;
  int n_fail  = 0;

  // Bench-side timing model: what out_valid must be and whether the last
  // edge was a reset edge.
  logic exp_ov  = 1'b0;
  logic was_rst = 1'b1;
  always @(posedge clk) begin
    exp_ov  <= rst_n && in_valid;
    was_rst <= !rst_n;
  end

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Monitor: one line per delivered transaction.
  initial begin : monitor
    int hold_p;
    int hold_c;
    exp_t e;
    hold_p = 0;
    hold_c = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (was_rst) begin
        chk("reset_product", $signed(product), 0);
        chk("reset_carry", {31'b0, carry}, 0);
        chk("reset_out_valid", {31'b0, out_valid}, 0);
        hold_p = 0;
        hold_c = 0;
      end else begin
        chk("out_valid_latency", {31'b0, out_valid}, {31'b0, exp_ov});
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = sb.pop_front();
            $display("[TB] %0d * %0d -> product %0d carry %0d (expect %0d/%0d)",
                     e.a, e.b, $signed(product), carry, e.p, e.c);
            chk("product", $signed(product), e.p);
            chk("carry", {31'b0, carry}, e.c);
            hold_p = e.p;
            hold_c = e.c;
          end
        end else begin
          chk("hold_product", $signed(product), hold_p);
          chk("hold_carry", {31'b0, carry}, hold_c);
        end
      end
    end
  end

  task automatic drive(input logic v, input int a, input int b,
                       input int p, input int c);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = v;
    in1      = 9'(a);
    in2      = 9'(b);
    if (v) begin
      e.a = a; e.b = b; e.p = p; e.c = c;
      sb.push_back(e);
    end
  endtask

  task automatic drive_vec(input logic v, input int idx);
    drive(v, vecs[idx].a, vecs[idx].b, vecs[idx].p, vecs[idx].c);
  endtask

  task automatic idle_junk();
    drive(1'b0, int'($urandom_range(0, 511)) - 256,
          int'($urandom_range(0, 511)) - 256, 0, 0);
  endtask

  initial begin : stim
    vecs = '{
      '{  -8,    9,    -72, 0},
      '{  20,    4,     80, 0},
      '{   8,    2,     16, 0},
      '{   1,    1,      1, 0},
      '{   0,   18,      0, 0},
      '{  15,    5,     76, 0},
      '{  50,    7,    336, 0},
      '{  25,    6,    136, 0},
      '{ 129,   65,   8384, 0},
      '{ 255,  255,  65024, 0},
      '{-256, -256,  65535, 1},
      '{-256,  255, -65280, 0},
      '{-256,    1,   -256, 0},
      '{  -3,   -3,      8, 0},
      '{   7,   -1,     -7, 0},
      '{ -17,    0,      0, 0}
    };

    // Reset held for two edges with in_valid asserted.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in1      = 9'sd15;
    in2      = 9'sd5;
    repeat (2) @(posedge clk);

    // Each vector followed by an idle cycle with junk operands (hold check).
    idle_junk();
    for (int i = 0; i < 16; i++) begin
      drive_vec(1'b1, i);
      idle_junk();
    end

    // Back-to-back streaming.
    for (int i = 0; i < 16; i++) drive_vec(1'b1, i);

    // Streaming with in_valid toggling.
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 2) idle_junk();
      drive_vec(1'b1, 15 - i);
    end

    // Reset arriving together with a valid pair: that pair is discarded.
    drive_vec(1'b1, 9);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in1      = 9'sd50;
    in2      = 9'sd7;
    idle_junk();
    drive_vec(1'b1, 6);
    drive_vec(1'b1, 10);
    idle_junk();
    idle_junk();
    idle_junk();

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ilm_mult.md
Name: ilm_mult

Overview:
- Signed approximate multiplier using the Improved Logarithmic Multiplier (ILM) algorithm.
- Each operand magnitude is rounded to its nearest power of two, and the product is formed from shifts and adds only.
- Sits in the approximate-arithmetic datapath. It has a single registered output stage with one-cycle latency.

Parameters:
- IN_W, 9, operand width (two's complement).
- OUT_W, 2*IN_W-1 (17), product width (two's complement); not independently settable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands valid this cycle.
- in1  in  IN_W  multiplicand, signed.
- in2  in  IN_W  multiplier, signed.
- out_valid  out  1  product/carry valid.
- product  out  OUT_W  signed approximate product.
- carry  out  1  overflow flag; product was saturated.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n); the polarity and synchronicity are fixed.
- Reset: on a clk edge with rst_n=0, product=0, carry=0, out_valid=0. Reset mid-stream discards the pending result.
- Latency: 1 cycle.
  - On each clk edge with rst_n=1: out_valid<=in_valid.
  - When in_valid=1: product/carry <= f(in1,in2).
  - When in_valid=0: product/carry hold.
  - No backpressure; a new operand pair may be accepted every cycle.
- Sign handling:
  - s = sign(in1) XOR sign(in2).
  - Magnitudes |in1|, |in2| are IN_W-bit unsigned; -256 gives 256.
- Zero: if either magnitude is 0, the result is product=0, carry=0.
- Rounding per magnitude m>0:
  - k = index of the leading one.
  - If k>0 and bit k-1 is 1, round up: P2 = 2^(k+1), K = k+1.
  - Otherwise P2 = 2^k, K = k.
  - The tie case (m = 3*2^(k-1)) rounds up.
  - q = m - P2 (signed; negative when rounded up).
- Approximate magnitude: M = 2^(Ka+Kb) + qa*2^Kb + qb*2^Ka.
  - Compute in at least 19-bit signed intermediate; M is always >= 0.
- Output: R = s ? -M : M.
  - If R is outside [-65536, 65535], product saturates to 65535 (positive) or -65536 (negative) and carry=1.
  - Otherwise product=R and carry=0.
  - With IN_W=9, the only overflow case is (-256)*(-256).
- Exact results occur whenever both q are 0, or one q is 0 and the other operand is an exact power of two.

Decomposition:
- Shared package ilm_pkg holds:
  - IN_W/OUT_W constants.
  - Intermediate width constant MAG_W=2*IN_W+1.
  - Saturation limits PROD_MAX/PROD_MIN.
- One sub-module, ilm_round_pow2. Input: unsigned magnitude. Outputs: K, signed q, zero flag. It contains the leading-one detector and rounding logic and is instantiated twice.
- The top level does sign extraction, shift/add, negation, saturation and the output register.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> product=0, carry=0, out_valid=0. Deassert -> out_valid follows in_valid one cycle later.
- Exact/sign cases:
  - in1=-8, in2=9 -> product=-72, carry=0.
  - in1=20, in2=4 -> 80.
  - in1=8, in2=2 -> 16.
  - in1=1, in2=1 -> 1.
  - in1=0, in2=18 -> 0.
- Approximation cases:
  - in1=15, in2=5 -> 76.
  - in1=50, in2=7 -> 336.
  - in1=25, in2=6 -> 136.
  - in1=129, in2=65 -> 8384.
  - in1=255, in2=255 -> 65024, carry=0.
- Overflow/extremes:
  - in1=-256, in2=-256 -> product=65535, carry=1.
  - in1=-256, in2=255 -> -65280, carry=0.
  - in1=-256, in2=1 -> -256.
- Streaming: back-to-back pairs every cycle with in_valid toggling -> each result appears exactly 1 cycle after its operands. Outputs hold while in_valid=0.
- Exhaustive: all 512x512 operand pairs vs a software ILM model -> bit-exact product and carry.
